// File: rtl/serial_2c_receiver.sv
// ----------------------------------------------------------------------------
// serial_2c_receiver
//
// Purpose:
//   Receives framed, LSB-first serial words in two's-complement form and
//   rebuilds them in parallel. At the same time it recovers the original value
//   by running the serial complement algorithm again: bits are copied up to
//   and including the first 1, and every later bit is inverted. Each completed
//   frame goes into a one-entry valid/ready output register, so frame timing
//   is decoupled from the consumer.
//
// Parameters:
//   WIDTH      bits per serial frame (2..32)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   qualifies start/x this cycle; when low the receiver holds
//   start      marks bit 0 (LSB) of a frame; only meaningful with in_valid
//   x          serial data bit, LSB first
//   out_ready  consumer accepts the output word this cycle
//   out_valid  rx_word/dec_word/most_neg hold a word
//   rx_word    word exactly as received
//   dec_word   two's complement of rx_word (the recovered original)
//   most_neg   rx_word is 2^(WIDTH-1), whose negation is not representable
//   busy       a frame is in progress
//   overrun    one-cycle pulse: a completed frame was dropped (output full)
//   frame_err  one-cycle pulse: start arrived mid-frame and the frame restarted
// ----------------------------------------------------------------------------
module serial_2c_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             start,
    input  logic             x,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] rx_word,
    output logic [WIDTH-1:0] dec_word,
    output logic             most_neg,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE   = 2'd0;  // waiting for a frame
    localparam logic [1:0] COPY   = 2'd1;  // no 1 seen yet: dec bit = x
    localparam logic [1:0] INVERT = 2'd2;  // a 1 was seen: dec bit = ~x

    localparam logic [WIDTH-1:0] MOST_NEG_WORD = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state, state_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] rx_sr, dec_sr;
    logic [WIDTH-1:0] rx_next, dec_next;
    logic [CW-1:0]    pos;
    logic             accept;
    logic             restart;
    logic             complete;
    logic             out_free;

    // A start bit is always accepted. Without start a bit is accepted only
    // while a frame is open, so stray bits in IDLE are ignored.
    assign accept   = in_valid && (start || (state != IDLE));
    assign restart  = in_valid && start && (state != IDLE);
    assign out_free = !out_valid || out_ready;
    assign busy     = (state != IDLE);

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        count_next = count;
        rx_next    = rx_sr;
        dec_next   = dec_sr;
        pos        = count;
        complete   = 1'b0;

        if (accept) begin
            if (start) begin
                // A start bit always opens a new frame. In the middle of a frame
                // it throws away the partial word.
                pos        = '0;
                rx_next    = '0;
                dec_next   = '0;
                rx_next[0]  = x;
                dec_next[0] = x;
                state_next = x ? INVERT : COPY;
            end else begin
                rx_next[pos]  = x;
                dec_next[pos] = (state == COPY) ? x : ~x;
                state_next    = (state == COPY && !x) ? COPY : INVERT;
            end

            if (pos == CW'(WIDTH - 1)) begin
                complete   = 1'b1;
                state_next = IDLE;
                count_next = '0;
            end else begin
                count_next = pos + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge, whatever the statement
    // order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            rx_sr     <= '0;
            dec_sr    <= '0;
            out_valid <= 1'b0;
            rx_word   <= '0;
            dec_word  <= '0;
            most_neg  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            rx_sr     <= rx_next;
            dec_sr    <= dec_next;
            frame_err <= restart;
            overrun   <= complete && !out_free;

            // A completion that finds the register free (or being drained this
            // cycle) loads it. Otherwise the held word wins and the new one is
            // dropped.
            if (complete && out_free) begin
                out_valid <= 1'b1;
                rx_word   <= rx_next;
                dec_word  <= dec_next;
                most_neg  <= (rx_next == MOST_NEG_WORD);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_2c_receiver.sv
// ----------------------------------------------------------------------------
// tb_serial_2c_receiver
//
// Directed testbench for serial_2c_receiver (WIDTH=8). Inputs change on the
// falling edge. Outputs are sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_serial_2c_receiver;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             start;
    logic             x;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] rx_word;
    logic [WIDTH-1:0] dec_word;
    logic             most_neg;
    logic             busy;
    logic             overrun;
    logic             frame_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    serial_2c_receiver #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .start     (start),
        .x         (x),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .rx_word   (rx_word),
        .dec_word  (dec_word),
        .most_neg  (most_neg),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted bit. The task returns 1 ns after the edge that took the bit.
    task automatic send_bit(input logic s, input logic b);
        @(negedge clk);
        in_valid = 1'b1;
        start    = s;
        x        = b;
        @(posedge clk);
        #1;
    endtask

    // One cycle with in_valid low.
    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        x        = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) send_bit(i == 0, w[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; start = 1'b0; x = 1'b0; out_ready = 1'b1;
        #2;
        chk_cnt++;
        if ({out_valid, rx_word, dec_word, most_neg, busy, overrun, frame_err} !== '0)
            $display("FAIL reset_state got v=%b rx=%h dec=%h mn=%b busy=%b ov=%b fe=%b exp all 0",
                     out_valid, rx_word, dec_word, most_neg, busy, overrun, frame_err);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        send_word(8'h05);
        chk_cnt++;
        if ({out_valid, rx_word, dec_word, most_neg} !== {1'b1, 8'h05, 8'hFB, 1'b0})
            $display("FAIL single_05 got v=%b rx=%h dec=%h mn=%b exp v=1 rx=05 dec=FB mn=0",
                     out_valid, rx_word, dec_word, most_neg);
        else pass_cnt++;
        idle_cycle();
        chk_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL single_drain got out_valid=%b exp 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] words [3] = '{8'h00, 8'h80, 8'hFF};
        logic [WIDTH-1:0] decs  [3] = '{8'h00, 8'h80, 8'h01};
        logic             mns   [3] = '{1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_word(words[k]);
            chk_cnt++;
            if ({out_valid, rx_word, dec_word, most_neg} !== {1'b1, words[k], decs[k], mns[k]})
                $display("FAIL b2b_%0d got v=%b rx=%h dec=%h mn=%b exp v=1 rx=%h dec=%h mn=%b",
                         k, out_valid, rx_word, dec_word, most_neg, words[k], decs[k], mns[k]);
            else pass_cnt++;
        end
        idle_cycle();
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_word(8'h03);
        chk_cnt++;
        if ({out_valid, rx_word, dec_word, overrun} !== {1'b1, 8'h03, 8'hFD, 1'b0})
            $display("FAIL ovr_first got v=%b rx=%h dec=%h ov=%b exp v=1 rx=03 dec=FD ov=0",
                     out_valid, rx_word, dec_word, overrun);
        else pass_cnt++;
        send_word(8'h7F);
        chk_cnt++;
        if ({out_valid, rx_word, dec_word, overrun} !== {1'b1, 8'h03, 8'hFD, 1'b1})
            $display("FAIL ovr_drop got v=%b rx=%h dec=%h ov=%b exp v=1 rx=03 dec=FD ov=1",
                     out_valid, rx_word, dec_word, overrun);
        else pass_cnt++;
        idle_cycle();
        chk_cnt++;
        if ({out_valid, rx_word, overrun} !== {1'b1, 8'h03, 1'b0})
            $display("FAIL ovr_pulse_end got v=%b rx=%h ov=%b exp v=1 rx=03 ov=0",
                     out_valid, rx_word, overrun);
        else pass_cnt++;
        out_ready = 1'b1;
        idle_cycle();
        chk_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL ovr_consume got out_valid=%b exp 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] w = 8'h0C;
        int busy_low = 0;
        int early_valid = 0;
        out_ready = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(i == 0, w[i]);
            if (i < WIDTH - 1) begin
                if (!busy) busy_low++;
                if (out_valid) early_valid++;
            end
            if (i == 2 || i == 5) begin
                for (int g = 0; g < 3; g++) begin
                    idle_cycle();
                    if (!busy) busy_low++;
                    if (out_valid) early_valid++;
                end
            end
        end
        chk_cnt++;
        if (busy_low != 0)
            $display("FAIL stall_busy got %0d cycles with busy=0 exp 0", busy_low);
        else pass_cnt++;
        chk_cnt++;
        if (early_valid != 0)
            $display("FAIL stall_early got %0d early out_valid cycles exp 0", early_valid);
        else pass_cnt++;
        chk_cnt++;
        if ({out_valid, rx_word, dec_word, busy} !== {1'b1, 8'h0C, 8'hF4, 1'b0})
            $display("FAIL stall_word got v=%b rx=%h dec=%h busy=%b exp v=1 rx=0C dec=F4 busy=0",
                     out_valid, rx_word, dec_word, busy);
        else pass_cnt++;
    endtask

    task automatic test_restart();
        logic [WIDTH-1:0] w = 8'h11;
        int fe_cnt = 0;
        int valid_cnt = 0;
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        if (frame_err) fe_cnt++;
        send_bit(1'b1, w[0]);
        chk_cnt++;
        if (frame_err !== 1'b1)
            $display("FAIL restart_pulse got frame_err=%b exp 1", frame_err);
        else pass_cnt++;
        if (frame_err) fe_cnt++;
        if (out_valid) valid_cnt++;
        for (int i = 1; i < WIDTH; i++) begin
            send_bit(1'b0, w[i]);
            if (frame_err) fe_cnt++;
            if (i < WIDTH - 1 && out_valid) valid_cnt++;
        end
        chk_cnt++;
        if (fe_cnt != 1)
            $display("FAIL restart_count got %0d frame_err pulses exp 1", fe_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (valid_cnt != 0)
            $display("FAIL restart_aborted got %0d out_valid cycles exp 0", valid_cnt);
        else pass_cnt++;
        chk_cnt++;
        if ({out_valid, rx_word, dec_word, most_neg} !== {1'b1, 8'h11, 8'hEF, 1'b0})
            $display("FAIL restart_word got v=%b rx=%h dec=%h mn=%b exp v=1 rx=11 dec=EF mn=0",
                     out_valid, rx_word, dec_word, most_neg);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [WIDTH-1:0] w = 8'hA5;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(i == 0, w[i]);
        chk_cnt++;
        if ({out_valid, busy} !== 2'b11)
            $display("FAIL areset_pre got v=%b busy=%b exp v=1 busy=1", out_valid, busy);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if ({out_valid, rx_word, dec_word, most_neg, busy, overrun, frame_err} !== '0)
            $display("FAIL areset_now got v=%b rx=%h dec=%h mn=%b busy=%b ov=%b fe=%b exp all 0",
                     out_valid, rx_word, dec_word, most_neg, busy, overrun, frame_err);
        else pass_cnt++;
        @(negedge clk);
        in_valid  = 1'b0;
        start     = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        send_word(8'h40);
        chk_cnt++;
        if ({out_valid, rx_word, dec_word, most_neg} !== {1'b1, 8'h40, 8'hC0, 1'b0})
            $display("FAIL areset_after got v=%b rx=%h dec=%h mn=%b exp v=1 rx=40 dec=C0 mn=0",
                     out_valid, rx_word, dec_word, most_neg);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_stall();
        test_restart();
        test_async_reset();
        idle_cycle();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/serial_2c_receiver.md
Name: serial_2c_receiver

Overview:
- Receives framed, LSB-first serial words in two's-complement form, i.e. the bit stream our serial two's complementer produces.
- Rebuilds the received word in parallel.
- Applies the serial complement algorithm in the reverse direction (copy bits up to and including the first 1, then invert) to recover the original value.
- Presents both words through a one-entry valid/ready output register, so frame timing is decoupled from the consumer.

Parameters:
- WIDTH, 8, bits per serial frame; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  x/start qualify this cycle; when low, the receiver stalls
- start  input  1  marks the first bit (LSB) of a frame; only meaningful with in_valid
- x  input  1  serial data bit, LSB first
- out_ready  input  1  consumer accepts the output this cycle
- out_valid  output  1  rx_word/dec_word/most_neg hold a word
- rx_word  output  WIDTH  word exactly as received
- dec_word  output  WIDTH  two's complement of rx_word (recovered original)
- most_neg  output  1  rx_word == 1 followed by zeros (2^(WIDTH-1)); its negation is not representable
- busy  output  1  a frame is in progress (state != IDLE)
- overrun  output  1  one-cycle pulse: a completed frame was dropped because the output was full
- frame_err  output  1  one-cycle pulse: start arrived mid-frame and the frame restarted

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, bit count=0, shift registers=0, out_valid=0, rx_word=0, dec_word=0, most_neg=0, overrun=0, frame_err=0, busy=0. Reset asserted mid-frame discards the partial frame.
- FSM states:
  - IDLE: waiting for a frame.
  - COPY: no 1 seen yet in this frame; dec bit = x.
  - INVERT: a 1 has been seen; dec bit = ~x.
- Only cycles with in_valid=1 are "accepted bits". When in_valid=0, state, count and registers hold.
- IDLE:
  - in_valid && start: capture bit 0; dec bit0 = x; count=1.
  - Next state is COPY if x==0, INVERT if x==1.
  - in_valid && !start: bit ignored, no flag.
- COPY: capture x at position count; dec bit = x; go to INVERT if x==1.
- INVERT: capture x; dec bit = ~x; stay in INVERT.
- Bits fill from LSB (position 0) upward. The bit accepted with count==WIDTH-1 completes the frame; state returns to IDLE on that edge.
- Mid-frame restart: in_valid && start while in COPY or INVERT.
  - Partial frame is discarded, frame_err pulses next cycle.
  - The current bit is treated as bit 0 of a new frame, using the same rules as IDLE.
- Completion and output register, evaluated on the completing edge:
  - Output free (out_valid==0, or out_ready==1 this cycle): load rx_word, dec_word and most_neg; set out_valid=1. out_valid is visible the cycle after the last bit is accepted (latency 1 clk from the last bit).
  - Output full and out_ready==0: drop the new word, keep the old one, pulse overrun for one cycle.
- out_valid clears on out_ready && out_valid unless a new completion loads in the same cycle, in which case it stays 1 with the new data.
- Outputs are stable while out_valid && !out_ready.
- A new frame may start the cycle after a completion. Back-to-back frames with no idle gap are legal.
- Arithmetic:
  - dec_word equals (~rx_word + 1) mod 2^WIDTH.
  - An all-zero word never leaves COPY, so dec_word=0.
  - For the most-negative word, dec_word==rx_word and most_neg=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=8; send 0x05 LSB first (1,0,1,0,0,0,0,0) with in_valid=1, out_ready=1 → one cycle after the 8th bit: out_valid=1, rx_word=0x05, dec_word=0xFB, most_neg=0.
- Send 0x00, then 0x80, then 0xFF back-to-back → dec_word 0x00/most_neg=0, then 0x80/most_neg=1, then 0x01; three out_valid words, no gap needed.
- out_ready=0; send 0x03 then 0x7F → output keeps 0x03/0xFD, overrun pulses one cycle after 0x7F completes. Then raise out_ready → word consumed, out_valid=0.
- Send 0x0C with in_valid dropped for 3 cycles after bits 2 and 5 → result 0x0C/0xF4. busy=1 throughout the frame; no extra or missing bit.
- Send 4 bits of a frame, then start with a new frame 0x11 → frame_err pulses once, output 0x11/0xEF, no output for the aborted frame.
- Assert reset asynchronously (between edges) after 5 bits → all outputs 0 immediately. After release, a full frame 0x40 gives 0x40/0xC0.
